// File: rtl/idli_grf_seq_m.sv
// Sequencer for the nibble-serial GRF: word phase, write-port arbitration,
// and PC boot/increment/branch generation.
module idli_grf_seq_m #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  PC_INC   = 4'h1
) (
  input  logic       i_seq_gck,
  input  logic       i_seq_rst,
  input  logic       i_seq_core_req,
  input  logic [2:0] i_seq_core_addr,
  input  logic [3:0] i_seq_core_data,
  output logic       o_seq_core_gnt,
  input  logic       i_seq_dbg_req,
  input  logic [2:0] i_seq_dbg_addr,
  input  logic [3:0] i_seq_dbg_data,
  output logic       o_seq_dbg_gnt,
  input  logic       i_seq_pc_inc,
  input  logic       i_seq_br_vld,
  input  logic [3:0] i_seq_br_data,
  input  logic [3:0] i_seq_pc_data,
  output logic [2:0] o_seq_a,
  output logic       o_seq_a_vld,
  output logic [3:0] o_seq_a_data,
  output logic       o_seq_pc_vld,
  output logic [3:0] o_seq_pc_data,
  output logic [1:0] o_seq_phase,
  output logic       o_seq_boot
);

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [1:0] PM_NONE = 2'd0;
  localparam logic [1:0] PM_INC  = 2'd1;
  localparam logic [1:0] PM_BR   = 2'd2;

  logic [1:0] phase_q;
  logic [0:0] state_q;
  logic       rr_dbg_q;
  logic       carry_q;
  logic       act_q;
  logic       sel_dbg_q;
  logic [2:0] addr_q;
  logic [1:0] mode_q;

  logic       ph0, run, arb;
  logic       core_win, dbg_win, win;
  logic [2:0] win_addr;
  logic       pc_hit;
  logic       wr_act, wr_dbg;
  logic [2:0] wr_addr;
  logic [1:0] mode;
  logic [4:0] sum;

  assign ph0 = (phase_q == 2'd0);
  assign run = (state_q == ST_RUN);
  assign arb = run & ph0;

  // Round-robin only matters on a tie; rr_dbg_q names who wins it.
  assign core_win = arb & i_seq_core_req
                  & (~i_seq_dbg_req | ~rr_dbg_q);
  assign dbg_win  = arb & i_seq_dbg_req
                  & (~i_seq_core_req | rr_dbg_q);
  assign win      = core_win | dbg_win;
  assign win_addr = dbg_win ? i_seq_dbg_addr
                            : i_seq_core_addr;
  assign pc_hit   = win & (win_addr == 3'b111);

  assign wr_act  = ph0 ? win      : act_q;
  assign wr_dbg  = ph0 ? dbg_win  : sel_dbg_q;
  assign wr_addr = ph0 ? win_addr : addr_q;

  always_comb begin
    mode = mode_q;
    if (ph0) begin
      if (pc_hit)
        mode = PM_NONE;
      else if (i_seq_br_vld)
        mode = PM_BR;
      else if (i_seq_pc_inc)
        mode = PM_INC;
      else
        mode = PM_NONE;
    end
  end

  assign sum = {1'b0, i_seq_pc_data}
             + {1'b0, (ph0 ? PC_INC : 4'h0)}
             + {4'h0, (~ph0 & carry_q)};

  always_comb begin
    o_seq_core_gnt = 1'b0;
    o_seq_dbg_gnt  = 1'b0;
    o_seq_a        = 3'd0;
    o_seq_a_vld    = 1'b0;
    o_seq_a_data   = 4'h0;
    o_seq_pc_vld   = 1'b0;
    o_seq_pc_data  = 4'h0;
    o_seq_phase    = 2'd0;
    o_seq_boot     = 1'b0;
    if (i_seq_rst) begin
      o_seq_boot = 1'b1;
    end else if (!run) begin
      o_seq_boot    = 1'b1;
      o_seq_phase   = phase_q;
      o_seq_pc_vld  = 1'b1;
      o_seq_pc_data = RESET_PC[{phase_q, 2'b00} +: 4];
    end else begin
      o_seq_phase    = phase_q;
      o_seq_core_gnt = core_win;
      o_seq_dbg_gnt  = dbg_win;
      if (wr_act) begin
        o_seq_a_vld  = 1'b1;
        o_seq_a      = wr_addr;
        o_seq_a_data = wr_dbg ? i_seq_dbg_data
                              : i_seq_core_data;
      end
      unique case (mode)
        PM_BR: begin
          o_seq_pc_vld  = 1'b1;
          o_seq_pc_data = i_seq_br_data;
        end
        PM_INC: begin
          o_seq_pc_vld  = 1'b1;
          o_seq_pc_data = sum[3:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_seq_gck) begin
    if (i_seq_rst) begin
      phase_q   <= 2'd0;
      state_q   <= ST_BOOT;
      rr_dbg_q  <= 1'b0;
      carry_q   <= 1'b0;
      act_q     <= 1'b0;
      sel_dbg_q <= 1'b0;
      addr_q    <= 3'd0;
      mode_q    <= PM_NONE;
    end else begin
      phase_q <= phase_q + 2'd1;
      carry_q <= sum[4];
      if (!run && phase_q == 2'd3)
        state_q <= ST_RUN;
      if (ph0) begin
        act_q     <= win;
        sel_dbg_q <= dbg_win;
        addr_q    <= win_addr;
        mode_q    <= mode;
      end
      if (win)
        rr_dbg_q <= core_win;
    end
  end

endmodule

// File: tb/tb_idli_grf_seq_m.sv
// Scoreboard bench for idli_grf_seq_m: word-level reference model
// pushes per-cycle expectations; a negedge monitor compares.
module tb_idli_grf_seq_m;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] PC_INC   = 16'h0001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       core_req = 1'b0;
  logic [2:0] core_addr = '0;
  logic [3:0] core_data = '0;
  logic       core_gnt;
  logic       dbg_req = 1'b0;
  logic [2:0] dbg_addr = '0;
  logic [3:0] dbg_data = '0;
  logic       dbg_gnt;
  logic       pc_inc = 1'b0;
  logic       br_vld = 1'b0;
  logic [3:0] br_data = '0;
  logic [3:0] pc_nib = '0;
  logic [2:0] a;
  logic       a_vld;
  logic [3:0] a_data;
  logic       pc_vld;
  logic [3:0] pc_data;
  logic [1:0] phase;
  logic       boot;

  idli_grf_seq_m #(
    .RESET_PC(RESET_PC),
    .PC_INC  (PC_INC[3:0])
  ) dut (
    .i_seq_gck      (clk),
    .i_seq_rst      (rst),
    .i_seq_core_req (core_req),
    .i_seq_core_addr(core_addr),
    .i_seq_core_data(core_data),
    .o_seq_core_gnt (core_gnt),
    .i_seq_dbg_req  (dbg_req),
    .i_seq_dbg_addr (dbg_addr),
    .i_seq_dbg_data (dbg_data),
    .o_seq_dbg_gnt  (dbg_gnt),
    .i_seq_pc_inc   (pc_inc),
    .i_seq_br_vld   (br_vld),
    .i_seq_br_data  (br_data),
    .i_seq_pc_data  (pc_nib),
    .o_seq_a        (a),
    .o_seq_a_vld    (a_vld),
    .o_seq_a_data   (a_data),
    .o_seq_pc_vld   (pc_vld),
    .o_seq_pc_data  (pc_data),
    .o_seq_phase    (phase),
    .o_seq_boot     (boot)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       cg;
    logic       dg;
    logic [2:0] a;
    logic       av;
    logic [3:0] ad;
    logic       pv;
    logic [3:0] pd;
    logic [1:0] ph;
    logic       boot;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  bit   jitter = 0;
  string tag = "reset";

  // Reference model state: GRF PC and the requester favoured on a tie.
  logic [15:0] pc = 16'h0;
  bit          pref_dbg = 0;

  always @(negedge clk) begin
    obs_t e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = '{core_gnt, dbg_gnt, a, a_vld, a_data,
            pc_vld, pc_data, phase, boot};
      checks++;
      if (g === e)
        passed++;
      else
        $display("FAIL %s: got cg%b dg%b a%0d av%b ad%h pv%b pd%h ph%0d bt%b, required cg%b dg%b a%0d av%b ad%h pv%b pd%h ph%0d bt%b",
          tag, g.cg, g.dg, g.a, g.av, g.ad, g.pv, g.pd, g.ph, g.boot,
          e.cg, e.dg, e.a, e.av, e.ad, e.pv, e.pd, e.ph, e.boot);
    end
  end

  task automatic idle_inputs();
    core_req = 0; core_addr = 0; core_data = 0;
    dbg_req = 0; dbg_addr = 0; dbg_data = 0;
    pc_inc = 0; br_vld = 0; br_data = 0; pc_nib = 0;
  endtask

  task automatic push_reset();
    obs_t e;
    e = '0;
    e.boot = 1'b1;
    exp_q.push_back(e);
    pref_dbg = 0;
  endtask

  task automatic cyc_rst();
    @(posedge clk); #1;
    rst = 1;
    idle_inputs();
    push_reset();
  endtask

  task automatic boot_word();
    obs_t e;
    for (int ph = 0; ph < 4; ph++) begin
      @(posedge clk); #1;
      rst = 0;
      idle_inputs();
      pc_nib = pc[4*ph +: 4];
      e = '0;
      e.pv = 1'b1;
      e.pd = RESET_PC[4*ph +: 4];
      e.ph = 2'(ph);
      e.boot = 1'b1;
      exp_q.push_back(e);
    end
    pc = RESET_PC;
  endtask

  task automatic word(
    input bit cr, input logic [2:0] ca, input logic [15:0] cd,
    input bit dr, input logic [2:0] da, input logic [15:0] dd,
    input bit inc, input bit br, input logic [15:0] bd,
    input int abort_ph
  );
    bit cw, dw, win, hit;
    logic [2:0] waddr;
    logic [15:0] wdata, newpc;
    bit pcu;
    obs_t e;
    cw = cr && (!dr || !pref_dbg);
    dw = dr && (!cr || pref_dbg);
    win = cw || dw;
    waddr = dw ? da : ca;
    wdata = dw ? dd : cd;
    hit = win && waddr == 3'd7;
    pcu = !hit && (br || inc);
    newpc = br ? bd : pc + PC_INC;
    for (int ph = 0; ph < 4; ph++) begin
      @(posedge clk); #1;
      if (ph == abort_ph) begin
        rst = 1;
        idle_inputs();
        push_reset();
        return;
      end
      rst = 0;
      if (ph == 0 || !jitter) begin
        core_req = cr; core_addr = ca;
        dbg_req = dr; dbg_addr = da;
        pc_inc = inc; br_vld = br;
      end else begin
        core_req = 1'($urandom); core_addr = 3'($urandom);
        dbg_req = 1'($urandom); dbg_addr = 3'($urandom);
        pc_inc = 1'($urandom); br_vld = 1'($urandom);
      end
      core_data = cd[4*ph +: 4];
      dbg_data = dd[4*ph +: 4];
      br_data = bd[4*ph +: 4];
      pc_nib = pc[4*ph +: 4];
      e = '0;
      e.ph = 2'(ph);
      if (ph == 0) begin
        e.cg = cw;
        e.dg = dw;
      end
      if (win) begin
        e.av = 1'b1;
        e.a = waddr;
        e.ad = wdata[4*ph +: 4];
      end
      if (pcu) begin
        e.pv = 1'b1;
        e.pd = newpc[4*ph +: 4];
      end
      exp_q.push_back(e);
    end
    if (win) pref_dbg = cw;
    if (hit) pc = wdata;
    else if (pcu) pc = newpc;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    repeat (3) cyc_rst();
    tag = "boot";
    boot_word();

    tag = "core_wr";
    word(1, 3'd3, 16'h4321, 0, 0, 0, 0, 0, 0, 4);

    tag = "rr";
    repeat (3) word(1, 3'd1, 16'hA5A5, 1, 3'd2, 16'h5A5A, 0, 0, 0, 4);

    tag = "inc_00ff";
    word(1, 3'd7, 16'h00FF, 0, 0, 0, 0, 0, 0, 4);
    word(0, 0, 0, 0, 0, 0, 1, 0, 0, 4);
    tag = "inc_ffff";
    word(1, 3'd7, 16'hFFFF, 0, 0, 0, 0, 0, 0, 4);
    word(0, 0, 0, 0, 0, 0, 1, 0, 0, 4);
    tag = "inc_after_wrap";
    word(0, 0, 0, 0, 0, 0, 1, 0, 0, 4);

    tag = "branch";
    word(0, 0, 0, 0, 0, 0, 1, 1, 16'hBEEF, 4);
    tag = "pc_conflict";
    word(1, 3'd7, 16'h1234, 0, 0, 0, 1, 1, 16'h5555, 4);
    word(0, 0, 0, 1, 3'd7, 16'h0FF0, 1, 0, 0, 4);

    tag = "mid_reset";
    word(1, 3'd3, 16'h9999, 0, 0, 0, 1, 0, 0, 2);
    tag = "reboot";
    boot_word();
    word(1, 3'd4, 16'h7777, 1, 3'd5, 16'h8888, 1, 0, 0, 4);

    tag = "random";
    jitter = 1;
    for (int i = 0; i < 80; i++) begin
      word(1'($urandom), 3'($urandom), 16'($urandom),
           1'($urandom), 3'($urandom), 16'($urandom),
           1'($urandom), ($urandom_range(0, 3) == 0),
           16'($urandom),
           ($urandom_range(0, 29) == 0) ? 1 : 4);
      if (rst) boot_word();
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, required 0",
               exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
